sfifo_rd_stream: RTL and testbench



---
 rtl/sfifo_rd_pkg.sv | 16 +
 rtl/sfifo_rd_pbuf.sv | 60 ++++++
 rtl/sfifo_rd_stream.sv | 104 ++++++++++
 tb/tb_sfifo_rd_stream.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_rd_pkg.sv
// Shared constants and sizing helpers for the sfifo read-stream adapter.
package sfifo_rd_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    // Enough entries to absorb every in-flight read plus one word being held.
    function automatic int unsigned buf_depth(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sfifo_rd_pbuf.sv
// Circular prefetch buffer: push/pop with wrapping pointers and an occupancy count.
module sfifo_rd_pbuf
    import sfifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned LVL_W = level_width(DEPTH),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop_ok   = pop_i & (level_q != '0);
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push_i) - LVL_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (level_q == LVL_W'(DEPTH))));

endmodule

// File: rtl/sfifo_rd_stream.sv
// Drains a fixed-latency synchronous FIFO into a first-word-fall-through valid/ready stream.
// Optional statistics counters are enabled with macro SFIFO_RD_STREAM_STAT_EN.
module sfifo_rd_stream
    import sfifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned BUF_DEPTH = buf_depth(RD_LAT),
    localparam int unsigned LVL_W     = level_width(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_ren,
    input  logic [WIDTH-1:0] fifo_rdat,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [LVL_W-1:0] buf_level
`ifdef SFIFO_RD_STREAM_STAT_EN
    ,
    output logic [31:0]      rd_word_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sfifo_rd_stream: RD_LAT out of range");
    end

    localparam logic [LVL_W:0] DEPTH_C = BUF_DEPTH[LVL_W:0];

    logic [RD_LAT-1:0] infl_q, infl_d;
    logic [LVL_W-1:0]  inflight;
    logic              push;
    logic              pop;

    // Credit counts reads in flight plus words held; a same-cycle pop is ignored
    // so fifo_ren has no combinational path from m_ready.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + LVL_W'(infl_q[i]);
        end
        fifo_ren = rst_n & ~fifo_empty &
                   (({1'b0, inflight} + {1'b0, buf_level}) < DEPTH_C);
        infl_d   = RD_LAT'({infl_q, fifo_ren});
        push     = infl_q[RD_LAT-1];
        pop      = m_valid & m_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= '0;
        end else begin
            infl_q <= infl_d;
        end
    end

    sfifo_rd_pbuf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_pbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (fifo_rdat),
        .pop_i   (pop),
        .rdata_o (m_data),
        .level_o (buf_level)
    );

    assign m_valid = (buf_level != '0);

`ifdef SFIFO_RD_STREAM_STAT_EN
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        word_cnt_d  = word_cnt_q + 32'(pop);
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rd_word_cnt = word_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

    a_no_ren_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_ren && fifo_empty));

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench for sfifo_rd_stream: lane 0 uses RD_LAT=1, lane 1 uses RD_LAT=2, each fed by a FIFO model.
module tb_sfifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ren   [2];
    logic [7:0] rdat  [2];
    logic       empty [2];
    logic       valid [2];
    logic       ready [2];
    logic [7:0] mdat  [2];
    logic [1:0] lvl0;
    logic [2:0] lvl1;
    logic [2:0] lvl   [2];
`ifdef SFIFO_RD_STREAM_STAT_EN
    logic [31:0] wcnt [2];
    logic [15:0] scnt [2];
`endif

    logic [7:0] mem [2][2048];
    int         wr_idx [2];
    int         rd_idx [2];
    logic [7:0] p1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sfifo_rd_stream #(.WIDTH(8), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .fifo_ren(ren[0]), .fifo_rdat(rdat[0]),
        .fifo_empty(empty[0]), .m_valid(valid[0]), .m_ready(ready[0]),
        .m_data(mdat[0]), .buf_level(lvl0)
`ifdef SFIFO_RD_STREAM_STAT_EN
        , .rd_word_cnt(wcnt[0]), .stall_cnt(scnt[0])
`endif
    );

    sfifo_rd_stream #(.WIDTH(8), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .fifo_ren(ren[1]), .fifo_rdat(rdat[1]),
        .fifo_empty(empty[1]), .m_valid(valid[1]), .m_ready(ready[1]),
        .m_data(mdat[1]), .buf_level(lvl1)
`ifdef SFIFO_RD_STREAM_STAT_EN
        , .rd_word_cnt(wcnt[1]), .stall_cnt(scnt[1])
`endif
    );

    assign lvl[0]   = {1'b0, lvl0};
    assign lvl[1]   = lvl1;
    assign empty[0] = (wr_idx[0] == rd_idx[0]);
    assign empty[1] = (wr_idx[1] == rd_idx[1]);

    // FIFO models: lane 0 returns data one cycle after ren, lane 1 two cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx[0] <= 0;
            rd_idx[1] <= 0;
            rdat[0]   <= '0;
            rdat[1]   <= '0;
            p1        <= '0;
        end else begin
            if (ren[0]) begin
                rdat[0]   <= mem[0][rd_idx[0]];
                rd_idx[0] <= rd_idx[0] + 1;
            end
            if (ren[1]) begin
                p1        <= mem[1][rd_idx[1]];
                rd_idx[1] <= rd_idx[1] + 1;
            end
            rdat[1] <= p1;
        end
    end

    task automatic push_word(input int k, input logic [7:0] v);
        mem[k][wr_idx[k]] = v;
        wr_idx[k] = wr_idx[k] + 1;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        wr_idx[0] = 0;
        wr_idx[1] = 0;
        ready[0]  = 1'b1;
        ready[1]  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        push_word(0, 8'h5A);
        push_word(1, 8'hA5);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ren[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ren lane%0d got %b want 0", k, ren[k]); end
            n_cmp++; if (valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid lane%0d got %b want 0", k, valid[k]); end
            n_cmp++; if (mdat[k] !== 8'h00) begin n_bad++; $display("FAIL reset_data lane%0d got %h want 00", k, mdat[k]); end
            n_cmp++; if (lvl[k] !== 3'd0) begin n_bad++; $display("FAIL reset_level lane%0d got %0d want 0", k, lvl[k]); end
        end
    endtask

    task automatic test_first_word_lat1();
        logic       exp_ren, exp_v;
        logic [7:0] exp_d;
        hold_reset();
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        push_word(0, 8'h33);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_ren = (c < 3);
            exp_v   = (c >= 2 && c <= 4);
            n_cmp++; if (ren[0] !== exp_ren) begin n_bad++; $display("FAIL lat1_ren c%0d got %b want %b", c, ren[0], exp_ren); end
            n_cmp++; if (valid[0] !== exp_v) begin n_bad++; $display("FAIL lat1_valid c%0d got %b want %b", c, valid[0], exp_v); end
            if (exp_v) begin
                exp_d = 8'((c - 1) * 8'h11);
                n_cmp++; if (mdat[0] !== exp_d) begin n_bad++; $display("FAIL lat1_data c%0d got %h want %h", c, mdat[0], exp_d); end
            end
        end
        n_cmp++; if (lvl[0] !== 3'd0) begin n_bad++; $display("FAIL lat1_level_end got %0d want 0", lvl[0]); end
    endtask

    task automatic test_throughput_lat2();
        logic exp_v;
        hold_reset();
        for (int i = 0; i < 10; i++) push_word(1, 8'($urandom));
        rst_n = 1'b1;
        for (int c = 0; c < 17; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_v = (c >= 3 && c < 13);
            n_cmp++; if (valid[1] !== exp_v) begin n_bad++; $display("FAIL lat2_valid c%0d got %b want %b", c, valid[1], exp_v); end
            if (exp_v) begin
                n_cmp++; if (mdat[1] !== mem[1][c-3]) begin n_bad++; $display("FAIL lat2_data c%0d got %h want %h", c, mdat[1], mem[1][c-3]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nren = 0;
        int nout = 0;
        hold_reset();
        for (int i = 0; i < 8; i++) push_word(1, 8'($urandom));
        ready[1] = 1'b0;
        rst_n    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ren[1] === 1'b1) nren++;
            n_cmp++; if (ren[1] && empty[1]) begin n_bad++; $display("FAIL bp_ren_empty c%0d got 1 want 0", c); end
            if (c >= 3) begin
                n_cmp++; if (valid[1] !== 1'b1 || mdat[1] !== mem[1][0]) begin n_bad++; $display("FAIL bp_hold c%0d got v=%b d=%h want v=1 d=%h", c, valid[1], mdat[1], mem[1][0]); end
            end
        end
        n_cmp++; if (nren != 4) begin n_bad++; $display("FAIL bp_ren_pulses got %0d want 4", nren); end
        n_cmp++; if (lvl[1] !== 3'd4) begin n_bad++; $display("FAIL bp_level got %0d want 4", lvl[1]); end
        for (int c = 0; c < 40 && nout < 8; c++) begin
            @(negedge clk);
            ready[1] = 1'b1;
            #1;
            if (valid[1] && ready[1]) begin
                n_cmp++; if (mdat[1] !== mem[1][nout]) begin n_bad++; $display("FAIL bp_drain word%0d got %h want %h", nout, mdat[1], mem[1][nout]); end
                nout++;
            end
        end
        n_cmp++; if (nout != 8) begin n_bad++; $display("FAIL bp_drain_count got %0d want 8", nout); end
    endtask

    task automatic test_random(input int k);
        int depth  = (k == 0) ? 3 : 4;
        int pushed = 0;
        int nout   = 0;
        int nstall = 0;
        hold_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 20000 && nout < 1000; c++) begin
            if (c > 0) @(negedge clk);
            if (pushed < 1000 && ($urandom % 4) != 0) begin
                push_word(k, 8'($urandom));
                pushed++;
            end
            ready[k] = 1'($urandom % 2);
            #1;
            if (ren[k] && empty[k]) begin n_cmp++; n_bad++; $display("FAIL rnd_ren_empty lane%0d c%0d got 1 want 0", k, c); end
            if (int'(lvl[k]) > depth) begin n_cmp++; n_bad++; $display("FAIL rnd_level lane%0d got %0d want <=%0d", k, lvl[k], depth); end
            if (valid[k] && !ready[k]) nstall++;
            if (valid[k] && ready[k]) begin
                n_cmp++;
                if (nout >= wr_idx[k]) begin
                    n_bad++; $display("FAIL rnd_extra lane%0d word%0d got %h want none", k, nout, mdat[k]);
                end else if (mdat[k] !== mem[k][nout]) begin
                    n_bad++; $display("FAIL rnd_order lane%0d word%0d got %h want %h", k, nout, mdat[k], mem[k][nout]);
                end
                nout++;
            end
        end
        n_cmp++; if (nout != 1000) begin n_bad++; $display("FAIL rnd_count lane%0d got %0d want 1000", k, nout); end
        @(negedge clk);
        ready[k] = 1'b1;
        #1;
        n_cmp++; if (valid[k] !== 1'b0) begin n_bad++; $display("FAIL rnd_dup lane%0d got valid %b want 0", k, valid[k]); end
`ifdef SFIFO_RD_STREAM_STAT_EN
        n_cmp++; if (wcnt[k] !== 32'(nout)) begin n_bad++; $display("FAIL stat_words lane%0d got %0d want %0d", k, wcnt[k], nout); end
        n_cmp++; if (scnt[k] !== 16'(nstall)) begin n_bad++; $display("FAIL stat_stalls lane%0d got %0d want %0d", k, scnt[k], nstall); end
`endif
    endtask

    task automatic test_empty_midstream();
        int nout = 0;
        hold_reset();
        push_word(0, 8'hC1);
        push_word(0, 8'hC2);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 7) begin
                push_word(0, 8'hC3);
                push_word(0, 8'hC4);
                push_word(0, 8'hC5);
            end
            #1;
            n_cmp++; if (ren[0] && empty[0]) begin n_bad++; $display("FAIL empty_ren c%0d got 1 want 0", c); end
            if (c == 7) begin
                n_cmp++; if (ren[0] !== 1'b1) begin n_bad++; $display("FAIL empty_resume got %b want 1", ren[0]); end
            end
            if (valid[0] && ready[0]) begin
                n_cmp++; if (mdat[0] !== mem[0][nout]) begin n_bad++; $display("FAIL empty_order word%0d got %h want %h", nout, mdat[0], mem[0][nout]); end
                nout++;
            end
        end
        n_cmp++; if (nout != 5) begin n_bad++; $display("FAIL empty_count got %0d want 5", nout); end
    endtask

    task automatic test_reset_midstream();
        logic exp_v;
        hold_reset();
        for (int i = 0; i < 6; i++) push_word(0, 8'(8'hD0 + i));
        ready[0] = 1'b0;
        rst_n    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
        end
        n_cmp++; if (lvl[0] !== 3'd2) begin n_bad++; $display("FAIL mid_level_before got %0d want 2", lvl[0]); end
        #2;
        rst_n     = 1'b0;
        wr_idx[0] = 0;
        wr_idx[1] = 0;
        #1;
        n_cmp++; if (ren[0] !== 1'b0 || valid[0] !== 1'b0 || mdat[0] !== 8'h00 || lvl[0] !== 3'd0) begin
            n_bad++; $display("FAIL mid_async_clear got ren=%b v=%b d=%h lvl=%0d want all 0", ren[0], valid[0], mdat[0], lvl[0]);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ready[0] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) push_word(0, 8'hA5);
            #1;
            exp_v = (c == 7);
            n_cmp++; if (valid[0] !== exp_v) begin n_bad++; $display("FAIL mid_valid c%0d got %b want %b", c, valid[0], exp_v); end
            if (exp_v) begin
                n_cmp++; if (mdat[0] !== 8'hA5) begin n_bad++; $display("FAIL mid_data got %h want a5", mdat[0]); end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_idx[0] = 0;
        wr_idx[1] = 0;
        ready[0]  = 1'b1;
        ready[1]  = 1'b1;
        test_reset();
        test_first_word_lat1();
        test_throughput_lat2();
        test_backpressure();
        test_random(0);
        test_random(1);
        test_empty_midstream();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
